// File: rtl/load_store_unit.sv
// load_store_unit: memory stage between EX and writeback.
// Accepts one load/store from EX, runs a single req/gnt/rvalid data-memory
// transaction and returns sign/zero-extended load data for writeback.
// Only one transaction is ever in flight; EX stalls while req_ready is low.
//
// Build option: define LSU_MISALIGN_TRAP_EN to reject misaligned halfword/word
// accesses with a one-cycle misalign pulse. Without it, misaligned accesses
// have their offending low address bits cleared and proceed normally.
//
// state | meaning
// IDLE  | ready for a new request from EX
// REQ   | dmem_req asserted, all dmem_* held until dmem_gnt
// WAIT  | load granted, waiting for dmem_rvalid

module load_store_unit #(
   parameter int XLEN = 32,
   parameter int RD_W = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_we,
   input  logic [2:0]      req_funct3,
   input  logic [XLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_wdata,
   input  logic [RD_W-1:0] req_rd,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [XLEN-1:0] dmem_addr,
   output logic [3:0]      dmem_be,
   output logic [XLEN-1:0] dmem_wdata,
   input  logic            dmem_gnt,
   input  logic            dmem_rvalid,
   input  logic [XLEN-1:0] dmem_rdata,
   output logic            wb_valid,
   output logic [RD_W-1:0] wb_rd,
   output logic [XLEN-1:0] wb_data,
   output logic            misalign
);

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic            accept;
   logic            go;
   logic            trap_req;
   logic [1:0]      req_size;
   logic [1:0]      req_off;
   logic [3:0]      be_nxt;
   logic [XLEN-1:0] wdata_nxt;

   logic            we_q;
   logic            uns_q;
   logic [1:0]      size_q;
   logic [1:0]      off_q;
   logic [XLEN-1:0] addr_q;
   logic [3:0]      be_q;
   logic [XLEN-1:0] wdata_q;
   logic [RD_W-1:0] rd_q;

   logic [7:0]      ld_byte;
   logic [15:0]     ld_half;
   logic [XLEN-1:0] ld_ext;
   logic            rvalid_take;

   logic            wb_valid_q;
   logic [RD_W-1:0] wb_rd_q;
   logic [XLEN-1:0] wb_data_q;

   assign req_size = req_funct3[1:0];
   assign accept   = req_valid & req_ready;

`ifdef LSU_MISALIGN_TRAP_EN
   // halfword on an odd byte, or word off a word boundary (size 3 behaves as word)
   assign trap_req = ((req_size == SZ_H) & req_addr[0]) |
                     (req_size[1] & (req_addr[1:0] != 2'b00));
`else
   assign trap_req = 1'b0;
`endif

   // a trapped request is consumed in IDLE and never reaches the bus
   assign go = accept & ~trap_req;

   // request decode: lane offset (misaligned low bits dropped), byte enables, replicated store data
   always_comb begin
      req_off   = 2'b00;
      be_nxt    = 4'b1111;
      wdata_nxt = req_wdata;
      case (req_size)
         SZ_B: begin
            req_off   = req_addr[1:0];
            be_nxt    = 4'b0001 << req_addr[1:0];
            wdata_nxt = {4{req_wdata[7:0]}};
         end
         SZ_H: begin
            req_off   = {req_addr[1], 1'b0};
            be_nxt    = 4'b0011 << {req_addr[1], 1'b0};
            wdata_nxt = {2{req_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (go)          state_nxt = REQ;
         REQ:     if (dmem_gnt)    state_nxt = we_q ? IDLE : WAIT;
         WAIT:    if (dmem_rvalid) state_nxt = IDLE;
         default:                  state_nxt = IDLE;
      endcase
   end

   // state-decoded handshake outputs
   always_comb begin
      req_ready = (state == IDLE);
      dmem_req  = (state == REQ);
   end

   // capture the request on acceptance; these registers drive dmem_* and stay put until gnt
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q    <= 1'b0;
         uns_q   <= 1'b0;
         size_q  <= 2'b00;
         off_q   <= 2'b00;
         addr_q  <= '0;
         be_q    <= 4'b0000;
         wdata_q <= '0;
         rd_q    <= '0;
      end else if (go) begin
         we_q    <= req_we;
         uns_q   <= req_funct3[2];
         size_q  <= req_size;
         off_q   <= req_off;
         addr_q  <= {req_addr[XLEN-1:2], 2'b00};
         be_q    <= be_nxt;
         wdata_q <= wdata_nxt;
         rd_q    <= req_rd;
      end
   end

   assign dmem_we    = we_q;
   assign dmem_addr  = addr_q;
   assign dmem_be    = be_q;
   assign dmem_wdata = wdata_q;

   // load lane select and sign/zero extension from the latched offset and size
   always_comb begin
      ld_byte = dmem_rdata[7:0];
      case (off_q)
         2'd1:    ld_byte = dmem_rdata[15:8];
         2'd2:    ld_byte = dmem_rdata[23:16];
         2'd3:    ld_byte = dmem_rdata[31:24];
         default: ld_byte = dmem_rdata[7:0];
      endcase
      ld_half = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      case (size_q)
         SZ_B:    ld_ext = {{24{ld_byte[7] & ~uns_q}}, ld_byte};
         SZ_H:    ld_ext = {{16{ld_half[15] & ~uns_q}}, ld_half};
         default: ld_ext = dmem_rdata;
      endcase
   end

   // rvalid only counts while a load is actually waiting; stray beats elsewhere are dropped
   assign rvalid_take = (state == WAIT) & dmem_rvalid;

   // writeback register: one-cycle valid pulse with the extended data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_valid_q <= 1'b0;
         wb_rd_q    <= '0;
         wb_data_q  <= '0;
      end else begin
         wb_valid_q <= rvalid_take;
         if (rvalid_take) begin
            wb_rd_q   <= rd_q;
            wb_data_q <= ld_ext;
         end
      end
   end

   assign wb_valid = wb_valid_q;
   assign wb_rd    = wb_rd_q;
   assign wb_data  = wb_data_q;

`ifdef LSU_MISALIGN_TRAP_EN
   logic misalign_q;

   // misalign pulse in the cycle after a trapped request is accepted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) misalign_q <= 1'b0;
      else        misalign_q <= accept & trap_req;
   end

   assign misalign = misalign_q;
`else
   assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
`timescale 1ns/1ps
// Scoreboard bench for load_store_unit: stimulus pushes expected bus and
// writeback transactions, a monitor pops and compares as the DUT presents them.

module tb_load_store_unit;

`ifdef LSU_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'd0;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic [4:0]  req_rd = 5'd0;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic        dmem_gnt = 1'b0;
   logic        dmem_rvalid = 1'b0;
   logic [31:0] dmem_rdata = 32'd0;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        misalign;

   always #5 clk = ~clk;

   load_store_unit #(.XLEN(32), .RD_W(5)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
      .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
      .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .misalign(misalign)
   );

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic        we;
      int          ncyc;
   } dexp_t;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } wexp_t;

   dexp_t dq[$];
   wexp_t wq[$];
   int    mq = 0;

   int n_pass = 0;
   int n_tot  = 0;

   // memory contents: a fixed hash of the word address unless a test pins the value
   logic        ovr_en = 1'b0;
   logic [31:0] ovr_data = 32'd0;

   int          ph = 0;
   int          rcnt = 0;
   int          gdly = 0;
   int          rdly = 0;
   logic [31:0] ld_wa = 32'd0;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   function automatic logic [31:0] word_for(logic [31:0] wa);
      if (ovr_en) return ovr_data;
      return {wa[15:0], ~wa[31:16]} ^ 32'h5A5AC3C3;
   endfunction

   // reference model: byte-level view of the access
   task automatic expect_txn(logic we, logic [2:0] f3, logic [31:0] addr, logic [31:0] wd,
                             logic [4:0] rd, int gd);
      int          nb;
      int          off;
      dexp_t       d;
      wexp_t       w;
      logic [31:0] mask;
      logic [31:0] v;
      nb  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      off = int'(addr[1:0]);
      if (TRAP && (off % nb) != 0) begin
         mq++;
         return;
      end
      off     = off - (off % nb);
      d.addr  = {addr[31:2], 2'b00};
      d.be    = 4'b0000;
      for (int i = 0; i < nb; i++) d.be[off + i] = 1'b1;
      for (int j = 0; j < 4; j++) d.wdata[8*j +: 8] = wd[8*(j % nb) +: 8];
      d.we    = we;
      d.ncyc  = gd + 1;
      dq.push_back(d);
      if (!we) begin
         v = word_for(d.addr) >> (8 * off);
         if (nb < 4) begin
            mask = (32'd1 << (8 * nb)) - 32'd1;
            v = v & mask;
            if (!f3[2] && v[8*nb-1]) v = v | ~mask;
         end
         w.rd   = rd;
         w.data = v;
         wq.push_back(w);
      end
   endtask

   // drive one request, caller sits just after a falling edge
   task automatic issue(logic we, logic [2:0] f3, logic [31:0] addr, logic [31:0] wd,
                        logic [4:0] rd, int gd, int rl);
      int n = 0;
      while (!req_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) chk("ready_timeout", 32'(req_ready), 32'd1);
      gdly       = gd;
      rdly       = rl;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wd;
      req_rd     = rd;
      req_valid  = 1'b1;
      expect_txn(we, f3, addr, wd, rd, gd);
      @(negedge clk);
      req_valid  = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((dq.size() != 0 || wq.size() != 0 || mq != 0 || ph != 0) && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("drain_timeout", 32'(n < 500), 32'd1);
      repeat (2) @(negedge clk);
   endtask

   // memory responder: gnt after gdly waiting cycles, rvalid rdly cycles after gnt, junk rvalid elsewhere
   initial begin
      forever begin
         @(negedge clk);
         #1;
         dmem_gnt    = 1'b0;
         dmem_rvalid = 1'b0;
         dmem_rdata  = $urandom;
         if (ph == 2) begin
            if (rcnt == rdly) begin
               dmem_rvalid = 1'b1;
               dmem_rdata  = word_for(ld_wa);
               ph   = 0;
               rcnt = 0;
            end else begin
               rcnt++;
            end
         end else if (dmem_req) begin
            if (rcnt == gdly) begin
               dmem_gnt = 1'b1;
               rcnt     = 0;
               if (!dmem_we) begin
                  ph    = 2;
                  ld_wa = dmem_addr;
               end
            end else begin
               rcnt++;
               dmem_rvalid = 1'($urandom_range(0, 1));
            end
         end else begin
            rcnt = 0;
            dmem_rvalid = 1'($urandom_range(0, 1));
         end
      end
   end

   // monitor: compare whatever the DUT presents against the scoreboard heads
   initial begin
      int rq_cyc = 0;
      forever begin
         @(negedge clk);
         #2;
         if (!rst_n) begin
            rq_cyc = 0;
         end else begin
            if (dmem_req) begin
               if (dq.size() == 0) begin
                  chk("dmem_req_unexpected", 32'(dmem_req), 32'd0);
               end else begin
                  chk("dmem_addr", dmem_addr, dq[0].addr);
                  chk("dmem_be", 32'(dmem_be), 32'(dq[0].be));
                  chk("dmem_we", 32'(dmem_we), 32'(dq[0].we));
                  if (dq[0].we) chk("dmem_wdata", dmem_wdata, dq[0].wdata);
                  rq_cyc++;
                  if (dmem_gnt) begin
                     chk("req_cycles", rq_cyc, dq[0].ncyc);
                     void'(dq.pop_front());
                     rq_cyc = 0;
                  end
               end
            end else if (rq_cyc != 0) begin
               chk("dmem_req_dropped", 32'(dmem_req), 32'd1);
               rq_cyc = 0;
            end
            if (wb_valid) begin
               if (wq.size() == 0) begin
                  chk("wb_valid_unexpected", 32'(wb_valid), 32'd0);
               end else begin
                  chk("wb_rd", 32'(wb_rd), 32'(wq[0].rd));
                  chk("wb_data", wb_data, wq[0].data);
                  void'(wq.pop_front());
               end
            end
            if (misalign) begin
               if (mq == 0) chk("misalign_unexpected", 32'(misalign), 32'd0);
               else begin
                  n_tot++;
                  n_pass++;
                  mq--;
               end
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_dmem_req", 32'(dmem_req), 32'd0);
      chk("rst_wb_valid", 32'(wb_valid), 32'd0);
      chk("rst_misalign", 32'(misalign), 32'd0);
      chk("rst_dmem_be", 32'(dmem_be), 32'd0);
      chk("rst_wb_data", wb_data, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // SB to top lane, grant after two wait cycles
      issue(1'b1, 3'd0, 32'h0000_1003, 32'h0000_00AB, 5'd0, 2, 0);
      drain();

      // LB / LBU from lane 2
      ovr_en = 1'b1;
      ovr_data = 32'h0080_0000;
      issue(1'b0, 3'd0, 32'h0000_2002, 32'd0, 5'd7, 0, 0);
      issue(1'b0, 3'd4, 32'h0000_2002, 32'd0, 5'd8, 1, 2);
      drain();

      // LH upper half
      ovr_data = 32'hBEEF_1234;
      issue(1'b0, 3'd1, 32'h0000_2002, 32'd0, 5'd13, 0, 1);
      issue(1'b0, 3'd5, 32'h0000_2002, 32'd0, 5'd14, 0, 0);
      drain();

      // misaligned word load
      ovr_data = 32'hCAFE_F00D;
      issue(1'b0, 3'd2, 32'h0000_3001, 32'd0, 5'd3, 1, 0);
      issue(1'b1, 3'd1, 32'h0000_3003, 32'h1234_5678, 5'd0, 0, 0);
      drain();

      // reset while waiting for load data; the late rvalid must be ignored
      ovr_en = 1'b0;
      issue(1'b0, 3'd2, 32'h0000_4000, 32'd0, 5'd9, 0, 6);
      n = 0;
      while (!(ph == 2 && !dmem_req) && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("reach_wait", 32'(n < 50), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_req_ready", 32'(req_ready), 32'd1);
      chk("abort_dmem_req", 32'(dmem_req), 32'd0);
      chk("abort_wb_valid", 32'(wb_valid), 32'd0);
      dq.delete();
      wq.delete();
      mq = 0;
      @(negedge clk);
      rst_n = 1'b1;
      drain();
      issue(1'b0, 3'd2, 32'h0000_5000, 32'd0, 5'd21, 1, 1);
      drain();

      // randomized traffic, often back-to-back with the previous writeback
      for (int k = 0; k < 200; k++) begin
         issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
               5'($urandom_range(0, 31)), $urandom_range(0, 3), $urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) @(negedge clk);
      end
      drain();

      chk("dq_empty", 32'(dq.size()), 32'd0);
      chk("wq_empty", 32'(wq.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
